// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP camera bring-up sequencer.
// State codes, table opcodes and bus field types live here.
package dvp_pkg;

    typedef logic [3:0]  state_t;
    typedef logic [7:0]  rom_addr_t;
    typedef logic [15:0] rom_word_t;

    localparam state_t S_IDLE     = 4'd0;
    localparam state_t S_RST_HOLD = 4'd1;
    localparam state_t S_RST_WAIT = 4'd2;
    localparam state_t S_FETCH    = 4'd3;
    localparam state_t S_DECODE   = 4'd4;
    localparam state_t S_START    = 4'd5;
    localparam state_t S_BIT      = 4'd6;
    localparam state_t S_STOP     = 4'd7;
    localparam state_t S_GAP      = 4'd8;
    localparam state_t S_DELAY    = 4'd9;
    localparam state_t S_FIN      = 4'd10;

    localparam rom_word_t END_MARK = 16'hFFFF;
    localparam logic [7:0] DELAY_OP = 8'hFE;

endpackage

// File: rtl/dvp_sccb_init_if.sv
// Control, table ROM and sensor pin bundle of the bring-up sequencer.
// master is the sequencer side, slave the surrounding system.
interface dvp_sccb_init_if;
    import dvp_pkg::*;

    logic      start;
    logic      busy;
    logic      done;
    rom_addr_t rom_addr;
    rom_word_t rom_data;
    logic      dvp_reseto_n;
    logic      sccb_sck_oe;
    logic      sccb_sio_oe;

    modport master (
        input  start, rom_data,
        output busy, done, rom_addr,
        output dvp_reseto_n, sccb_sck_oe, sccb_sio_oe
    );

    modport slave (
        output start, rom_data,
        input  busy, done, rom_addr,
        input  dvp_reseto_n, sccb_sck_oe, sccb_sio_oe
    );

endinterface

// File: rtl/sccb_tick_gen.sv
// Quarter-bit strobe for the SCCB engine.
// Free-running divide-by-QDIV with a synchronous restart.
module sccb_tick_gen #(
    parameter int QDIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(QDIV);
    localparam logic [CW-1:0] LAST = CW'(QDIV - 1);

    logic [CW-1:0] cnt;

    // count 0..QDIV-1, restart realigns the phase to zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/dvp_sccb_init.sv
// Camera bring-up: sensor reset pulse, settle wait, then one SCCB
// 3-phase write per ROM table entry until the end marker.
module dvp_sccb_init
    import dvp_pkg::*;
#(
    parameter int         CLOCKFREQ = 25000000,
    parameter int         SCCBFREQ  = 100000,
    parameter logic [7:0] DEVICE_ID = 8'h42,
    parameter int         RESET_MS  = 10,
    parameter int         SETTLE_MS = 20
) (
    input logic             clk,
    input logic             reset_n,
    dvp_sccb_init_if.master bus
);

    localparam int QDIV = CLOCKFREQ / (SCCBFREQ * 4);
    localparam logic [31:0] MS_CYC = 32'(CLOCKFREQ / 1000);
    localparam logic [31:0] RESET_CYC = 32'(RESET_MS) * MS_CYC;
    localparam logic [31:0] SETTLE_CYC = 32'(SETTLE_MS) * MS_CYC;

    state_t      state;
    rom_addr_t   idx;
    logic        rst_o;
    logic        sck_oe;
    logic        sio_oe;
    logic [31:0] mcnt;
    logic [1:0]  phase;
    logic [4:0]  slot;
    logic [3:0]  bpos;
    logic [23:0] shreg;
    logic        tick;
    logic        launch;
    logic        restart;
    logic        last_idx;

    // FIN is a one-cycle not-busy state, so a start there is honoured
    assign launch   = (state == S_IDLE || state == S_FIN) && bus.start;
    // realign ticks at DECODE so every write frame has exact timing
    assign restart  = launch || state == S_DECODE;
    assign last_idx = (idx == 8'hFF);

    sccb_tick_gen #(
        .QDIV(QDIV)
    ) u_tick (
        .clk(clk),
        .reset_n(reset_n),
        .restart(restart),
        .tick(tick)
    );

    // sequencer: reset pulse, table walk and bit-level SCCB framing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            idx    <= '0;
            rst_o  <= 1'b1;
            sck_oe <= 1'b0;
            sio_oe <= 1'b0;
            mcnt   <= '0;
            phase  <= '0;
            slot   <= '0;
            bpos   <= '0;
            shreg  <= '0;
        end else begin
            case (state)
                S_IDLE, S_FIN: begin
                    sck_oe <= 1'b0;
                    sio_oe <= 1'b0;
                    state  <= S_IDLE;
                    if (launch) begin
                        idx   <= '0;
                        rst_o <= 1'b0;
                        mcnt  <= RESET_CYC;
                        state <= S_RST_HOLD;
                    end
                end
                S_RST_HOLD: begin
                    if (mcnt <= 32'd1) begin
                        rst_o <= 1'b1;
                        mcnt  <= SETTLE_CYC;
                        state <= S_RST_WAIT;
                    end else begin
                        mcnt <= mcnt - 32'd1;
                    end
                end
                S_RST_WAIT: begin
                    if (mcnt <= 32'd1) begin
                        state <= S_FETCH;
                    end else begin
                        mcnt <= mcnt - 32'd1;
                    end
                end
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    unique case (1'b1)
                        bus.rom_data == END_MARK: begin
                            state <= S_FIN;
                        end
                        bus.rom_data[15:8] == DELAY_OP: begin
                            mcnt  <= {24'd0, bus.rom_data[7:0]} * MS_CYC;
                            state <= S_DELAY;
                        end
                        default: begin
                            shreg <= {DEVICE_ID, bus.rom_data};
                            phase <= '0;
                            state <= S_START;
                        end
                    endcase
                end
                S_START: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        unique case (phase)
                            2'd0: begin
                                sck_oe <= 1'b0;
                                sio_oe <= 1'b0;
                            end
                            2'd1: sio_oe <= 1'b1;
                            default: begin
                                sck_oe <= 1'b1;
                                phase  <= '0;
                                slot   <= '0;
                                bpos   <= '0;
                                state  <= S_BIT;
                            end
                        endcase
                    end
                end
                S_BIT: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        unique case (phase)
                            2'd0: begin
                                if (bpos == 4'd8) begin
                                    sio_oe <= 1'b0;
                                end else begin
                                    sio_oe <= ~shreg[23];
                                    shreg  <= {shreg[22:0], 1'b0};
                                end
                            end
                            2'd1: sck_oe <= 1'b0;
                            2'd2: ;
                            default: begin
                                sck_oe <= 1'b1;
                                bpos   <= (bpos == 4'd8) ? 4'd0 : bpos + 4'd1;
                                if (slot == 5'd26) begin
                                    state <= S_STOP;
                                end else begin
                                    slot <= slot + 5'd1;
                                end
                            end
                        endcase
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        unique case (phase)
                            2'd0: sio_oe <= 1'b1;
                            2'd1: sck_oe <= 1'b0;
                            default: begin
                                sio_oe <= 1'b0;
                                phase  <= '0;
                                state  <= S_GAP;
                            end
                        endcase
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        if (phase == 2'd3) begin
                            if (last_idx) begin
                                state <= S_FIN;
                            end else begin
                                idx   <= idx + 8'd1;
                                state <= S_FETCH;
                            end
                        end
                    end
                end
                S_DELAY: begin
                    if (mcnt <= 32'd1) begin
                        if (last_idx) begin
                            state <= S_FIN;
                        end else begin
                            idx   <= idx + 8'd1;
                            state <= S_FETCH;
                        end
                    end else begin
                        mcnt <= mcnt - 32'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = !(state == S_IDLE || state == S_FIN);
    assign bus.done         = (state == S_FIN);
    assign bus.rom_addr     = idx;
    assign bus.dvp_reseto_n = rst_o;
    assign bus.sccb_sck_oe  = sck_oe;
    assign bus.sccb_sio_oe  = sio_oe;

endmodule

// File: tb/tb_dvp_sccb_init.sv
// Bench for dvp_sccb_init: timeline model from the table contents,
// SCCB slave decoder on the pins, per-cycle output checks.
module tb_dvp_sccb_init;

    localparam int MS  = 4;
    localparam int Q   = 4;
    localparam int RST = 10 * MS;
    localparam int SET = 20 * MS;
    localparam int WR  = 118 * Q + 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int errors = 0;
    int checks = 0;

    logic [15:0] rom [256];
    logic [23:0] obs [$];
    int sck_rises = 0;

    dvp_sccb_init_if bus ();

    dvp_sccb_init #(
        .CLOCKFREQ(4000),
        .SCCBFREQ(250),
        .DEVICE_ID(8'h42),
        .RESET_MS(10),
        .SETTLE_MS(20)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // synchronous ROM, one cycle read latency
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // SCCB slave: decode START, sampled bits, STOP from line levels
    logic psck = 1'b1;
    logic psda = 1'b1;
    logic msck, msda;
    logic infr = 1'b0;
    int nbits = 0;
    logic [26:0] fr = '0;

    always @(negedge clk) begin
        msck = ~bus.sccb_sck_oe;
        msda = ~bus.sccb_sio_oe;
        if (!reset_n) begin
            infr = 1'b0;
            nbits = 0;
        end else if (!psck && msck) begin
            sck_rises++;
            if (infr && nbits < 27) begin
                fr = {fr[25:0], msda};
                nbits++;
            end
        end else if (psck && msck && psda && !msda) begin
            infr = 1'b1;
            nbits = 0;
        end else if (psck && msck && !psda && msda) begin
            if (infr && nbits == 27)
                obs.push_back({fr[26:19], fr[17:10], fr[8:1]});
            infr = 1'b0;
        end
        psck = msck;
        psda = msda;
    end

    task automatic run_seq(input string nm, input int start2_at,
                           input int reset_at, input int lit_tdone);
        int t;
        int tdone;
        int done_k;
        int ndone;
        int low_n;
        int c;
        int base;
        bit quiet [$];
        logic [23:0] expw [$];
        logic [7:0] prev_addr;
        logic [15:0] w;

        // model: cycle cost of each table entry, counted from start
        t = RST + SET;
        for (int i = 0; i < t; i++) quiet.push_back(1'b1);
        for (int n = 0; n < 256; n++) begin
            w = rom[n];
            quiet.push_back(1'b1);
            quiet.push_back(1'b1);
            if (w == 16'hFFFF) begin
                t += 2;
                break;
            end
            if (w[15:8] == 8'hFE) begin
                c = (w[7:0] == 8'd0) ? 1 : int'(w[7:0]) * MS;
                for (int j = 0; j < c; j++) quiet.push_back(1'b1);
                t += 2 + c;
            end else begin
                expw.push_back({8'h42, w});
                for (int j = 0; j < 114 * Q; j++) quiet.push_back(1'b0);
                for (int j = 0; j < 4 * Q; j++) quiet.push_back(1'b1);
                t += WR;
            end
        end
        tdone = t;

        obs.delete();
        base = sck_rises;
        done_k = -1;
        ndone = 0;
        low_n = 0;
        prev_addr = '0;
        @(posedge clk);
        #1 bus.start = 1'b1;
        for (int k = 0; k <= tdone + 3; k++) begin
            @(posedge clk);
            #1 bus.start = (k == start2_at);
            check({nm, " busy"}, bus.busy, k < tdone);
            check({nm, " done"}, bus.done, k == tdone);
            check({nm, " reseto_n"}, bus.dvp_reseto_n, k >= RST);
            if (k >= tdone || quiet[k]) begin
                check({nm, " sck idle"}, bus.sccb_sck_oe, 1'b0);
                check({nm, " sio idle"}, bus.sccb_sio_oe, 1'b0);
            end
            if (k <= tdone)
                check({nm, " addr order"}, bus.rom_addr >= prev_addr, 1'b1);
            prev_addr = bus.rom_addr;
            if (bus.done) begin
                ndone++;
                if (done_k < 0) done_k = k;
            end
            if (!bus.dvp_reseto_n) low_n++;
            if (k == reset_at) begin
                bus.start = 1'b0;
                reset_n = 1'b0;
                #1;
                check({nm, " rst sck"}, bus.sccb_sck_oe, 1'b0);
                check({nm, " rst sio"}, bus.sccb_sio_oe, 1'b0);
                check({nm, " rst reseto"}, bus.dvp_reseto_n, 1'b1);
                check({nm, " rst busy"}, bus.busy, 1'b0);
                check({nm, " rst done"}, bus.done, 1'b0);
                check({nm, " rst addr"}, bus.rom_addr, 8'h00);
                return;
            end
        end
        check({nm, " done count"}, ndone, 1);
        check({nm, " done time"}, done_k, tdone);
        check({nm, " reset low"}, low_n, RST);
        check({nm, " writes"}, obs.size(), expw.size());
        for (int i = 0; i < expw.size() && i < obs.size(); i++)
            check({nm, " write data"}, obs[i], expw[i]);
        check({nm, " sck rises"}, sck_rises - base, 28 * expw.size());
        if (lit_tdone >= 0)
            check({nm, " done literal"}, done_k, lit_tdone);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nent;
        bus.start = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        check("reset addr", bus.rom_addr, 8'h00);
        check("reset reseto", bus.dvp_reseto_n, 1'b1);
        check("reset sck", bus.sccb_sck_oe, 1'b0);
        check("reset sio", bus.sccb_sio_oe, 1'b0);
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(posedge clk);

        rom[0] = 16'h1280;
        rom[1] = 16'hFFFF;
        run_seq("t1", -1, -1, 596);
        check("t1 frame", (obs.size() > 0) ? {8'd0, obs[0]} : 32'hX, 32'h421280);

        rom[0] = 16'hFE05;
        rom[1] = 16'h1101;
        rom[2] = 16'hFFFF;
        run_seq("t2", -1, -1, 618);
        check("t2 frame", (obs.size() > 0) ? {8'd0, obs[0]} : 32'hX, 32'h421101);

        rom[0] = 16'hFFFF;
        run_seq("t3", -1, -1, 122);

        for (int i = 0; i < 256; i++) rom[i] = 16'hFE00;
        rom[3] = 16'h0000;
        rom[100] = 16'h0000;
        rom[255] = 16'h0000;
        run_seq("t4", -1, -1, 2301);
        check("t4 last addr", bus.rom_addr, 8'hFF);

        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = 16'h3355;
        run_seq("t5", 50, -1, 596);
        run_seq("t5b", 300, -1, 596);

        rom[0] = 16'h1280;
        run_seq("t6", -1, 160, -1);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(posedge clk);
        run_seq("t6 rerun", -1, -1, 596);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
            nent = $urandom_range(1, 3);
            for (int i = 0; i < nent; i++) begin
                if ($urandom_range(0, 2) == 0)
                    rom[i] = {8'hFE, 8'($urandom_range(0, 3))};
                else
                    rom[i] = {8'($urandom_range(0, 8'hFD)), 8'($urandom_range(0, 255))};
            end
            run_seq("rand", -1, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
